// File: rtl/alu_seq.sv
// alu_seq -- registered ALU with valid/ready handshakes on both sides.
//
// Single-cycle ops (add, sub, and, or, xor, shl, shr, nop, and div/mod by
// zero) are computed straight from the inputs on the accept edge. Their
// result and flags are loaded on that edge, and the FSM goes IDLE -> DONE.
// mul, and div/mod with a nonzero divisor, go IDLE -> BUSY and run WIDTH
// shift-add or restoring-division steps. The last step loads the result and
// flags and moves to DONE. The result is held in DONE until out_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands/opcode presented
//   in_ready   block can accept (IDLE and not in reset)
//   A, B       operands, WIDTH bits
//   operation  4-bit opcode
//   out_valid  result/flags valid, held until out_ready
//   out_ready  consumer accepts the result
//   result     registered result, WIDTH bits
//   N, Z, C, V registered negative / zero / carry / overflow flags
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_MOD = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_SHL = 4'b1000;
  localparam logic [3:0] OP_SHR = 4'b1001;

  // The shift amount is B[SW-1:0]. The iteration counter runs 0..WIDTH-1.
  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [3:0]       op_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg;   // mul: {product hi, multiplier/product lo}
                                      // div: {remainder, dividend/quotient}
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] result_reg;
  logic             n_reg, z_reg, c_reg, v_reg;

  logic accept;
  logic iter_op;
  logic last_iter;

  assign accept    = in_valid && in_ready;
  assign iter_op   = (operation == OP_MUL) ||
                     (((operation == OP_DIV) || (operation == OP_MOD)) && (B != '0));
  assign last_iter = (state_reg == BUSY) && (cnt_reg == CW'(WIDTH - 1));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = iter_op ? BUSY : DONE;
      BUSY: if (last_iter) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = rst_n && (state_reg == IDLE);
    out_valid = (state_reg == DONE);
  end

  // ------------------------------------------- single-cycle datapath
  logic [WIDTH-1:0] quick_res;
  logic             quick_c, quick_v;
  logic [WIDTH:0]   add_w, sub_w, shl_w, shr_w;
  logic [SW-1:0]    amt;

  always_comb begin
    amt   = B[SW-1:0];
    add_w = {1'b0, A} + {1'b0, B};
    sub_w = {1'b0, A} - {1'b0, B};
    // One extra bit catches the last bit shifted out on either side.
    shl_w = {1'b0, A} << amt;
    shr_w = {A, 1'b0} >> amt;

    quick_res = '0;
    quick_c   = 1'b0;
    quick_v   = 1'b0;
    case (operation)
      OP_ADD: begin
        quick_res = add_w[WIDTH-1:0];
        quick_c   = add_w[WIDTH];
        quick_v   = (A[WIDTH-1] == B[WIDTH-1]) && (add_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        quick_res = sub_w[WIDTH-1:0];
        quick_c   = ~sub_w[WIDTH];          // no borrow means A >= B
        quick_v   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_DIV, OP_MOD: begin
        // This path is reached only when B == 0.
        quick_res = '1;
        quick_v   = 1'b1;
      end
      OP_AND: quick_res = A & B;
      OP_OR:  quick_res = A | B;
      OP_XOR: quick_res = A ^ B;
      OP_SHL: begin
        quick_res = shl_w[WIDTH-1:0];
        quick_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        quick_res = shr_w[WIDTH:1];
        quick_c   = shr_w[0];
      end
      default: begin
        quick_res = '0;
      end
    endcase
  end

  // ---------------------------------------------- iterative datapath
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic             div_fits;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH-1:0] fin_res;
  logic             fin_cv;

  always_comb begin
    // Shift-add: add A to the high half when the multiplier LSB is set.
    // Then shift the whole {carry, hi, lo} right by one.
    mul_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, a_reg} : '0);

    // Restoring division: shift the next dividend bit into the remainder.
    // Subtract the divisor only when the remainder fits.
    div_shift = {hi_reg, lo_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_reg};
    div_fits  = (div_shift >= {1'b0, b_reg});

    if (op_reg == OP_MUL) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_reg[WIDTH-1:1]};
    end else begin
      step_hi = div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      step_lo = {lo_reg[WIDTH-2:0], div_fits};
    end

    fin_res = step_lo;
    fin_cv  = 1'b0;
    if (op_reg == OP_MUL) begin
      fin_cv = (step_hi != '0);
    end else if (op_reg == OP_MOD) begin
      fin_res = step_hi;
    end
  end

  // ------------------------------------- operand, work and output regs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      cnt_reg    <= '0;
      result_reg <= '0;
      n_reg      <= 1'b0;
      z_reg      <= 1'b0;
      c_reg      <= 1'b0;
      v_reg      <= 1'b0;
    end else begin
      if (state_reg == IDLE && accept) begin
        op_reg  <= operation;
        a_reg   <= A;
        b_reg   <= B;
        cnt_reg <= '0;
        if (iter_op) begin
          hi_reg <= '0;
          lo_reg <= (operation == OP_MUL) ? B : A;
        end else begin
          result_reg <= quick_res;
          n_reg      <= quick_res[WIDTH-1];
          z_reg      <= (quick_res == '0);
          c_reg      <= quick_c;
          v_reg      <= quick_v;
        end
      end else if (state_reg == BUSY) begin
        hi_reg  <= step_hi;
        lo_reg  <= step_lo;
        cnt_reg <= cnt_reg + CW'(1);
        if (last_iter) begin
          result_reg <= fin_res;
          n_reg      <= fin_res[WIDTH-1];
          z_reg      <= (fin_res == '0);
          c_reg      <= fin_cv;
          v_reg      <= fin_cv;
        end
      end
    end
  end

  assign result = result_reg;
  assign N      = n_reg;
  assign Z      = z_reg;
  assign C      = c_reg;
  assign V      = v_reg;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq -- self-checking bench for alu_seq (WIDTH=4).
// Directed cases cover multiply, add overflow, sub, div/mod, divide by zero,
// shifts, nop, backpressure and reset in the middle of a multiply. These are
// followed by randomized operations. Every operation is compared against an
// integer-arithmetic reference model. The model also gives the expected
// latency.
module tb_alu_seq;
  localparam int W  = 4;
  localparam int M  = (1 << W) - 1;
  localparam int SW = $clog2(W);

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic [3:0]   op_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         n_f, z_f, c_f, v_f;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a_in), .B(b_in), .operation(op_in), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .N(n_f), .Z(z_f), .C(c_f), .V(v_f)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int sx(input int x);
    return (x & (1 << (W - 1))) ? x - (1 << W) : x;
  endfunction

  // Reference model: plain integer arithmetic on the operand values.
  task automatic model(input int op, input int a, input int b,
                       output int r, output int n, output int z,
                       output int c, output int v);
    int s, amt, p;
    r = 0; c = 0; v = 0;
    amt = b & ((1 << SW) - 1);
    case (op)
      0: begin
        s = a + b; r = s & M; c = (s >> W) & 1;
        s = sx(a) + sx(b); v = (s > (M >> 1) || s < -(1 << (W - 1))) ? 1 : 0;
      end
      1: begin
        r = (a - b) & M; c = (a >= b) ? 1 : 0;
        s = sx(a) - sx(b); v = (s > (M >> 1) || s < -(1 << (W - 1))) ? 1 : 0;
      end
      2: begin p = a * b; r = p & M; c = ((p >> W) != 0) ? 1 : 0; v = c; end
      3: if (b == 0) begin r = M; v = 1; end else r = a / b;
      4: if (b == 0) begin r = M; v = 1; end else r = a % b;
      5: r = a & b;
      6: r = a | b;
      7: r = a ^ b;
      8: begin r = (a << amt) & M; c = (amt == 0) ? 0 : (a >> (W - amt)) & 1; end
      9: begin r = a >> amt;       c = (amt == 0) ? 0 : (a >> (amt - 1)) & 1; end
      default: r = 0;
    endcase
    n = (r >> (W - 1)) & 1;
    z = (r == 0) ? 1 : 0;
  endtask

  // Present one operation and wait for the result. Optionally hold out_ready
  // low for `hold` cycles while poking in_valid. Then hand the result off.
  task automatic run_op(input int op, input int a, input int b, input int hold);
    int r, n, z, c, v, e, exp_lat;
    model(op, a, b, r, n, z, c, v);
    exp_lat = (op == 2 || ((op == 3 || op == 4) && b != 0)) ? W + 1 : 1;
    check("ready_before", in_ready, 1);
    in_valid = 1'b1; a_in = W'(a); b_in = W'(b); op_in = 4'(op);
    @(posedge clk); #1;
    // Scramble the inputs after accept: the DUT must use its captured copy.
    in_valid = 1'b0; a_in = W'($urandom); b_in = W'($urandom); op_in = 4'($urandom);
    e = 1;
    while (!out_valid && e < 40) begin
      @(posedge clk); #1;
      e++;
    end
    check("latency", e, exp_lat);
    check("result", result, r);
    check("nzcv", {n_f, z_f, c_f, v_f}, {n[0], z[0], c[0], v[0]});
    check("ready_in_done", in_ready, 0);
    $display("txn op=%0d a=%0h b=%0h result=%0h nzcv=%b%b%b%b lat=%0d",
             op, a, b, result, n_f, z_f, c_f, v_f, e);
    if (hold > 0) begin
      in_valid = 1'b1;
      repeat (hold) begin @(posedge clk); #1; end
      check("bp_valid", out_valid, 1);
      check("bp_ready", in_ready, 0);
      check("bp_result", result, r);
      check("bp_nzcv", {n_f, z_f, c_f, v_f}, {n[0], z[0], c[0], v[0]});
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("handoff_valid", out_valid, 0);
    check("handoff_ready", in_ready, 1);
  endtask

  int d_op[10] = '{2, 0, 1, 3, 4, 3, 8, 9, 12, 4};
  int d_a[10]  = '{2, 7, 3, 11, 11, 11, 9, 9, 5, 5};
  int d_b[10]  = '{11, 1, 3, 2, 2, 0, 1, 0, 3, 0};

  initial begin
    int seen;
    #1 rst_n = 1'b0;
    #1;
    check("rst_result", result, 0);
    check("rst_nzcv", {n_f, z_f, c_f, v_f}, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("release_ready", in_ready, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_op(d_op[i], d_a[i], d_b[i], 0);

    // Backpressure on a multiply. shr 1001 >> 1 leaves a nonzero result
    // behind for the reset check that follows.
    run_op(2, 13, 7, 10);
    run_op(9, 9, 1, 0);

    // Assert reset asynchronously two cycles into a multiply.
    in_valid = 1'b1; a_in = 4'd3; b_in = 4'd5; op_in = 4'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("abort_result", result, 0);
    check("abort_nzcv", {n_f, z_f, c_f, v_f}, 0);
    check("abort_valid", out_valid, 0);
    check("abort_ready", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1 check("abort_release_ready", in_ready, 1);
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort_no_stale_valid", seen, 0);

    for (int i = 0; i < 40; i++)
      run_op($urandom_range(0, 15), $urandom_range(0, M), $urandom_range(0, M),
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out, expected completion");
    $fatal(1);
  end
endmodule
